// File: rtl/vc_pkg.sv
// Shared types and constants for the victim cache controller.
package vc_pkg;

  localparam int unsigned VC_SIZE = 8;
  localparam int unsigned IDX_W   = $clog2(VC_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SWAP,
    WB_REQ,
    WB_WAIT,
    INSERT,
    RESP
  } vc_state_t;

  function automatic logic [VC_SIZE-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [VC_SIZE-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/vc_victim_select.sv
// Hit-index encoder and victim choice: lowest invalid entry, else the PLRU pointer.
module vc_victim_select #(
  parameter int unsigned vc_size      = 8,
  parameter int unsigned num_idx_bits = $clog2(vc_size)
) (
  input  logic [vc_size-1:0]      hit_vec_i,
  input  logic [vc_size-1:0]      valid_i,
  input  logic [num_idx_bits-1:0] plru_i,
  output logic                    hit_o,
  output logic [num_idx_bits-1:0] hit_idx_o,
  output logic [num_idx_bits-1:0] vidx_o
);

  always_comb begin
    hit_o     = |hit_vec_i;
    hit_idx_o = '0;
    vidx_o    = plru_i;
    // Scan downwards so the lowest matching index wins.
    for (int i = int'(vc_size) - 1; i >= 0; i--) begin
      if (hit_vec_i[i]) hit_idx_o = num_idx_bits'(i);
      if (!valid_i[i])  vidx_o    = num_idx_bits'(i);
    end
  end

endmodule

// File: rtl/vc_controller.sv
// Victim cache sequencing FSM: swap on VC hit, insert (with optional L2 writeback) on miss.
module vc_controller
  import vc_pkg::*;
#(
  parameter int unsigned vc_size      = VC_SIZE,
  parameter int unsigned num_idx_bits = $clog2(vc_size)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    l1_req,
  input  logic                    l1_victim_valid,
  input  logic                    l1_victim_dirty,
  input  logic [vc_size-1:0]      vc_hit_vec,
  input  logic [vc_size-1:0]      vc_valid_dataout,
  input  logic [vc_size-1:0]      vc_dirty_dataout,
  input  logic [num_idx_bits-1:0] vc_plru_dataout,
  output logic [vc_size-1:0]      vc_valid_ld,
  output logic                    vc_valid_datain,
  output logic [vc_size-1:0]      vc_dirty_ld,
  output logic                    vc_dirty_datain,
  output logic                    vc_plru_ld,
  output logic [num_idx_bits-1:0] vc_plru_datain,
  output logic                    vc_valid_read,
  output logic                    vc_dirty_read,
  output logic                    vc_plru_read,
  output logic [vc_size-1:0]      vc_line_ld,
  output logic [num_idx_bits-1:0] vc_rd_idx,
  output logic                    l1_resp,
  output logic                    l1_hit,
  output logic                    l2_wb_req,
  input  logic                    l2_wb_resp
);

  localparam logic [vc_size-1:0] OneLsb = vc_size'(1);

  vc_state_t               state_q;
  logic                    hit_q;
  logic [num_idx_bits-1:0] hit_idx_q;
  logic [num_idx_bits-1:0] vidx_q;

  logic                    lk_hit;
  logic [num_idx_bits-1:0] lk_hit_idx;
  logic [num_idx_bits-1:0] lk_vidx;
  logic [vc_size-1:0]      hit_oh;
  logic [vc_size-1:0]      vidx_oh;

  vc_victim_select #(
    .vc_size      (vc_size),
    .num_idx_bits (num_idx_bits)
  ) u_victim_select (
    .hit_vec_i (vc_hit_vec),
    .valid_i   (vc_valid_dataout),
    .plru_i    (vc_plru_dataout),
    .hit_o     (lk_hit),
    .hit_idx_o (lk_hit_idx),
    .vidx_o    (lk_vidx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      vidx_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE:    if (l1_req) state_q <= LOOKUP;
        LOOKUP: begin
          hit_q     <= lk_hit;
          hit_idx_q <= lk_hit_idx;
          vidx_q    <= lk_vidx;
          if (lk_hit)                                                  state_q <= SWAP;
          else if (!l1_victim_valid)                                   state_q <= RESP;
          else if (vc_valid_dataout[lk_vidx] && vc_dirty_dataout[lk_vidx]) state_q <= WB_REQ;
          else                                                         state_q <= INSERT;
        end
        SWAP:    state_q <= RESP;
        WB_REQ:  state_q <= WB_WAIT;
        WB_WAIT: if (l2_wb_resp) state_q <= INSERT;
        INSERT:  state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit_oh  = OneLsb << hit_idx_q;
  assign vidx_oh = OneLsb << vidx_q;

  always_comb begin
    vc_valid_ld     = '0;
    vc_valid_datain = 1'b0;
    vc_dirty_ld     = '0;
    vc_dirty_datain = 1'b0;
    vc_plru_ld      = 1'b0;
    vc_plru_datain  = '0;
    vc_line_ld      = '0;
    vc_rd_idx       = '0;
    l1_resp         = 1'b0;
    l1_hit          = 1'b0;
    l2_wb_req       = 1'b0;
    vc_valid_read   = (state_q != IDLE);
    vc_dirty_read   = (state_q != IDLE);
    vc_plru_read    = (state_q != IDLE);
    unique case (state_q)
      SWAP: begin
        vc_rd_idx   = hit_idx_q;
        vc_valid_ld = hit_oh;
        // Without an L1 victim the hit line just moves to L1 and leaves the VC.
        if (l1_victim_valid) begin
          vc_line_ld      = hit_oh;
          vc_valid_datain = 1'b1;
          vc_dirty_ld     = hit_oh;
          vc_dirty_datain = l1_victim_dirty;
        end
      end
      WB_REQ: begin
        vc_rd_idx = vidx_q;
        l2_wb_req = 1'b1;
      end
      WB_WAIT: begin
        vc_rd_idx = vidx_q;
        l2_wb_req = 1'b1;
        if (l2_wb_resp) vc_dirty_ld = vidx_oh;
      end
      INSERT: begin
        vc_line_ld      = vidx_oh;
        vc_valid_ld     = vidx_oh;
        vc_valid_datain = 1'b1;
        vc_dirty_ld     = vidx_oh;
        vc_dirty_datain = l1_victim_dirty;
        vc_plru_ld      = 1'b1;
        vc_plru_datain  = (vidx_q == num_idx_bits'(vc_size - 1)) ? '0 : vidx_q + 1'b1;
      end
      RESP: begin
        l1_resp = 1'b1;
        l1_hit  = hit_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vc_controller.sv
// Self-checking bench for vc_controller; the bench also plays the VC metadata store.
module tb_vc_controller;
  import vc_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             l1_req, l1_victim_valid, l1_victim_dirty;
  logic [7:0]       vc_hit_vec, vc_valid_dataout, vc_dirty_dataout;
  logic [2:0]       vc_plru_dataout;
  logic [7:0]       vc_valid_ld, vc_dirty_ld, vc_line_ld;
  logic             vc_valid_datain, vc_dirty_datain, vc_plru_ld;
  logic [2:0]       vc_plru_datain, vc_rd_idx;
  logic             vc_valid_read, vc_dirty_read, vc_plru_read;
  logic             l1_resp, l1_hit, l2_wb_req, l2_wb_resp;
  logic [38:0]      all_out;

  int checks   = 0;
  int failures = 0;

  // Behavioural store contents seen by the controller.
  logic [7:0] m_valid, m_dirty;
  int         m_plru;

  typedef struct packed {
    logic [7:0] lat;
    logic       hit;
    logic [1:0] line_n;
    logic [7:0] line_ld;
    logic [1:0] valid_n;
    logic [7:0] valid_ld;
    logic       valid_din;
    logic [1:0] dirty_n;
    logic [7:0] dirty_ld0;
    logic       dirty_din0;
    logic [7:0] dirty_ld1;
    logic       dirty_din1;
    logic [1:0] plru_n;
    logic [2:0] plru_din;
    logic [7:0] wb_n;
    logic [2:0] rd_idx;
    logic       rd_stable;
    logic       strobes_ok;
    logic       quiet;
  } txn_t;

  vc_controller dut (
    .clk              (clk),
    .rst              (rst),
    .l1_req           (l1_req),
    .l1_victim_valid  (l1_victim_valid),
    .l1_victim_dirty  (l1_victim_dirty),
    .vc_hit_vec       (vc_hit_vec),
    .vc_valid_dataout (vc_valid_dataout),
    .vc_dirty_dataout (vc_dirty_dataout),
    .vc_plru_dataout  (vc_plru_dataout),
    .vc_valid_ld      (vc_valid_ld),
    .vc_valid_datain  (vc_valid_datain),
    .vc_dirty_ld      (vc_dirty_ld),
    .vc_dirty_datain  (vc_dirty_datain),
    .vc_plru_ld       (vc_plru_ld),
    .vc_plru_datain   (vc_plru_datain),
    .vc_valid_read    (vc_valid_read),
    .vc_dirty_read    (vc_dirty_read),
    .vc_plru_read     (vc_plru_read),
    .vc_line_ld       (vc_line_ld),
    .vc_rd_idx        (vc_rd_idx),
    .l1_resp          (l1_resp),
    .l1_hit           (l1_hit),
    .l2_wb_req        (l2_wb_req),
    .l2_wb_resp       (l2_wb_resp)
  );

  always #5 clk = ~clk;

  assign all_out = {vc_valid_ld, vc_valid_datain, vc_dirty_ld, vc_dirty_datain, vc_plru_ld,
                    vc_plru_datain, vc_valid_read, vc_dirty_read, vc_plru_read, vc_line_ld,
                    vc_rd_idx, l1_resp, l1_hit, l2_wb_req};

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  // Reference: expected activity of one request, and the resulting store contents.
  task automatic model_txn(input bit hit_en, input int hi, input bit vv, input bit vd,
                           input int wl, output txn_t e);
    int vidx;
    bit wb;
    e = '0;
    e.rd_stable  = 1'b1;
    e.strobes_ok = 1'b1;
    e.quiet      = 1'b1;
    if (hit_en) begin
      e.lat       = 8'd3;
      e.hit       = 1'b1;
      e.valid_n   = 2'd1;
      e.valid_ld  = onehot(IDX_W'(hi));
      e.valid_din = vv;
      e.rd_idx    = IDX_W'(hi);
      if (vv) begin
        e.line_n    = 2'd1;
        e.line_ld   = onehot(IDX_W'(hi));
        e.dirty_n   = 2'd1;
        e.dirty_ld0 = onehot(IDX_W'(hi));
        e.dirty_ld1 = onehot(IDX_W'(hi));
        e.dirty_din0 = vd;
        e.dirty_din1 = vd;
        m_valid[hi] = 1'b1;
        m_dirty[hi] = vd;
      end else begin
        m_valid[hi] = 1'b0;
      end
    end else if (!vv) begin
      e.lat = 8'd2;
    end else begin
      vidx = m_plru;
      for (int i = 0; i < 8; i++) begin
        if (!m_valid[i]) begin
          vidx = i;
          break;
        end
      end
      wb         = m_valid[vidx] && m_dirty[vidx];
      e.lat      = wb ? 8'(3 + wl) : 8'd3;
      e.line_n   = 2'd1;
      e.line_ld  = onehot(IDX_W'(vidx));
      e.valid_n  = 2'd1;
      e.valid_ld = onehot(IDX_W'(vidx));
      e.valid_din = 1'b1;
      e.dirty_ld0 = onehot(IDX_W'(vidx));
      e.dirty_ld1 = onehot(IDX_W'(vidx));
      e.dirty_din1 = vd;
      if (wb) begin
        e.dirty_n    = 2'd2;
        e.dirty_din0 = 1'b0;
        e.wb_n       = 8'(wl);
        e.rd_idx     = IDX_W'(vidx);
      end else begin
        e.dirty_n    = 2'd1;
        e.dirty_din0 = vd;
      end
      e.plru_n   = 2'd1;
      e.plru_din = IDX_W'((vidx + 1) % 8);
      m_valid[vidx] = 1'b1;
      m_dirty[vidx] = vd;
      m_plru        = (vidx + 1) % 8;
    end
  endtask

  // Drives one request from the current store image and records what the DUT did.
  task automatic do_txn(input bit hit_en, input int hi, input bit vv, input bit vd,
                        input int wl, output txn_t o);
    int wbc;
    bit done;
    o = '0;
    o.rd_stable  = 1'b1;
    o.strobes_ok = 1'b1;
    o.quiet      = 1'b1;
    wbc  = 0;
    done = 1'b0;
    @(negedge clk);
    l1_req           = 1'b1;
    l1_victim_valid  = vv;
    l1_victim_dirty  = vd;
    vc_hit_vec       = hit_en ? onehot(IDX_W'(hi)) : 8'h00;
    vc_valid_dataout = m_valid;
    vc_dirty_dataout = m_dirty;
    vc_plru_dataout  = IDX_W'(m_plru);
    assert ($onehot0(vc_hit_vec));
    #1;
    if (all_out !== '0) o.quiet = 1'b0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      l2_wb_resp = (wl >= 2) && (wbc == wl - 1);
      #1;
      if (!(vc_valid_read && vc_dirty_read && vc_plru_read)) o.strobes_ok = 1'b0;
      if (|vc_line_ld) begin
        o.line_n  = sat_inc(o.line_n);
        o.line_ld = o.line_ld | vc_line_ld;
      end
      if (|vc_valid_ld) begin
        o.valid_n   = sat_inc(o.valid_n);
        o.valid_ld  = o.valid_ld | vc_valid_ld;
        o.valid_din = vc_valid_datain;
        if (hit_en) o.rd_idx = vc_rd_idx;
      end
      if (|vc_dirty_ld) begin
        if (o.dirty_n == 2'd0) begin
          o.dirty_ld0  = vc_dirty_ld;
          o.dirty_din0 = vc_dirty_datain;
        end
        o.dirty_ld1  = vc_dirty_ld;
        o.dirty_din1 = vc_dirty_datain;
        o.dirty_n    = sat_inc(o.dirty_n);
      end
      if (vc_plru_ld) begin
        o.plru_n   = sat_inc(o.plru_n);
        o.plru_din = vc_plru_datain;
      end
      if (l2_wb_req) begin
        if (wbc == 0) o.rd_idx = vc_rd_idx;
        else if (vc_rd_idx !== o.rd_idx) o.rd_stable = 1'b0;
        wbc++;
      end
      if (l1_resp) begin
        o.lat  = 8'(cyc);
        o.hit  = l1_hit;
        done   = 1'b1;
        l1_req = 1'b0;
      end
    end
    l2_wb_resp = 1'b0;
    l1_req     = 1'b0;
    o.wb_n     = 8'(wbc);
    if (!done) begin
      o.lat = 8'hFF;
      rst   = 1'b0;
      @(negedge clk);
      rst   = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    l1_req = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (all_out !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got %h want 0", all_out);
      end
    end
    l1_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cold_insert();
    txn_t o, e;
    m_valid = 8'h00; m_dirty = 8'h00; m_plru = 5;
    do_txn(1'b0, 0, 1'b1, 1'b0, 2, o);
    model_txn(1'b0, 0, 1'b1, 1'b0, 2, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL cold_insert: got %p want %p", o, e);
    end
    checks++;
    if (o.line_ld !== 8'h01 || o.plru_din !== 3'd1 || o.lat !== 8'd3) begin
      failures++;
      $display("FAIL cold_insert_fields: got line=%h plru=%0d lat=%0d want 01/1/3",
               o.line_ld, o.plru_din, o.lat);
    end
  endtask

  task automatic test_hit_swap();
    txn_t o, e;
    m_valid = 8'h3F; m_dirty = 8'h00; m_plru = 2;
    do_txn(1'b1, 5, 1'b1, 1'b1, 2, o);
    model_txn(1'b1, 5, 1'b1, 1'b1, 2, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL hit_swap: got %p want %p", o, e);
    end
    checks++;
    if (o.rd_idx !== 3'd5 || o.plru_n !== 2'd0 || o.hit !== 1'b1 || o.dirty_din1 !== 1'b1) begin
      failures++;
      $display("FAIL hit_swap_fields: got rd=%0d plru_n=%0d hit=%b din=%b want 5/0/1/1",
               o.rd_idx, o.plru_n, o.hit, o.dirty_din1);
    end
  endtask

  task automatic test_dirty_wb();
    txn_t o, e;
    m_valid = 8'hFF; m_dirty = 8'h08; m_plru = 3;
    do_txn(1'b0, 0, 1'b1, 1'b0, 7, o);
    model_txn(1'b0, 0, 1'b1, 1'b0, 7, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL dirty_wb: got %p want %p", o, e);
    end
    checks++;
    if (o.wb_n !== 8'd7 || o.dirty_ld0 !== 8'h08 || o.dirty_din0 !== 1'b0 ||
        o.line_ld !== 8'h08 || o.plru_din !== 3'd4) begin
      failures++;
      $display("FAIL dirty_wb_fields: got wb=%0d dld=%h din=%b line=%h plru=%0d want 7/08/0/08/4",
               o.wb_n, o.dirty_ld0, o.dirty_din0, o.line_ld, o.plru_din);
    end
  endtask

  task automatic test_plru_wrap();
    txn_t o, e;
    m_valid = 8'hFF; m_dirty = 8'h00; m_plru = 7;
    do_txn(1'b0, 0, 1'b1, 1'b0, 2, o);
    model_txn(1'b0, 0, 1'b1, 1'b0, 2, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL plru_wrap: got %p want %p", o, e);
    end
    checks++;
    if (o.line_ld !== 8'h80 || o.plru_din !== 3'd0) begin
      failures++;
      $display("FAIL plru_wrap_fields: got line=%h plru=%0d want 80/0", o.line_ld, o.plru_din);
    end
  endtask

  task automatic test_hit_invalidate();
    txn_t o, e;
    m_valid = 8'hFF; m_dirty = 8'h04; m_plru = 0;
    do_txn(1'b1, 2, 1'b0, 1'b0, 2, o);
    model_txn(1'b1, 2, 1'b0, 1'b0, 2, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL hit_invalidate: got %p want %p", o, e);
    end
    checks++;
    if (o.line_n !== 2'd0 || o.valid_ld !== 8'h04 || o.valid_din !== 1'b0) begin
      failures++;
      $display("FAIL hit_invalidate_fields: got line_n=%0d vld=%h din=%b want 0/04/0",
               o.line_n, o.valid_ld, o.valid_din);
    end
  endtask

  task automatic test_no_victim();
    txn_t o, e;
    m_valid = 8'h0F; m_dirty = 8'h0F; m_plru = 1;
    do_txn(1'b0, 0, 1'b0, 1'b1, 2, o);
    model_txn(1'b0, 0, 1'b0, 1'b1, 2, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL no_victim: got %p want %p", o, e);
    end
  endtask

  task automatic test_reset_in_wb();
    bit seen;
    seen = 1'b0;
    m_valid = 8'hFF; m_dirty = 8'hFF; m_plru = 1;
    @(negedge clk);
    l1_req           = 1'b1;
    l1_victim_valid  = 1'b1;
    l1_victim_dirty  = 1'b0;
    vc_hit_vec       = 8'h00;
    vc_valid_dataout = m_valid;
    vc_dirty_dataout = m_dirty;
    vc_plru_dataout  = IDX_W'(m_plru);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (l2_wb_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_wb_reach: got l2_wb_req=0 want 1 within 20 cycles");
    end
    @(negedge clk);
    rst    = 1'b0;
    l1_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_in_wb: got %h want 0", all_out);
    end
    rst        = 1'b1;
    @(negedge clk);
    l2_wb_resp = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (all_out !== '0) begin
        failures++;
        $display("FAIL late_wb_resp: got %h want 0 (cycle %0d)", all_out, k);
      end
      @(negedge clk);
      l2_wb_resp = 1'b0;
    end
  endtask

  task automatic test_random();
    txn_t o, e;
    bit   hit_en, vv, vd;
    int   hi, wl, start;
    m_valid = 8'h00; m_dirty = 8'h00; m_plru = 0;
    for (int n = 0; n < 40; n++) begin
      hit_en = (m_valid != 8'h00) && ($urandom_range(0, 9) < 4);
      hi     = 0;
      if (hit_en) begin
        start = $urandom_range(0, 7);
        for (int j = 0; j < 8; j++) begin
          if (m_valid[(start + j) % 8]) begin
            hi = (start + j) % 8;
            break;
          end
        end
      end
      vv = ($urandom_range(0, 9) < 8);
      vd = 1'($urandom_range(0, 1));
      wl = $urandom_range(2, 6);
      do_txn(hit_en, hi, vv, vd, wl, o);
      model_txn(hit_en, hi, vv, vd, wl, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random_txn %0d: got %p want %p", n, o, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    l1_req = 1'b0; l1_victim_valid = 1'b0; l1_victim_dirty = 1'b0;
    vc_hit_vec = '0; vc_valid_dataout = '0; vc_dirty_dataout = '0; vc_plru_dataout = '0;
    l2_wb_resp = 1'b0;
    m_valid = '0; m_dirty = '0; m_plru = 0;
    test_reset();
    test_cold_insert();
    test_hit_swap();
    test_dirty_wb();
    test_plru_wrap();
    test_hit_invalidate();
    test_no_victim();
    test_reset_in_wb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_controller.md
Name: vc_controller

Overview:
- Sequencing FSM for the victim cache (VC).
- On each L1 miss it checks the VC hit vector.
- On a hit, it swaps the hit line with the L1 victim.
- On a miss, it inserts the L1 victim. If the displaced VC entry is valid and dirty, it is first written back to L2 through a req/resp handshake.
- It drives every load/datain control of the VC valid array, dirty array, PLRU register, tag array and data array, and sits between the L1 miss path and the L2 port.

Parameters:
- vc_size, 8, number of fully-associative VC entries.
- num_idx_bits, $clog2(vc_size), entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- l1_req  in  1  L1 miss request; level, held until l1_resp
- l1_victim_valid  in  1  L1 is evicting a valid line with this request
- l1_victim_dirty  in  1  dirty bit of the L1 victim
- vc_hit_vec  in  vc_size  per-entry tag match from the tag compare, qualified by valid
- vc_valid_dataout  in  vc_size  valid bits from the metadata store
- vc_dirty_dataout  in  vc_size  dirty bits from the metadata store
- vc_plru_dataout  in  num_idx_bits  replacement pointer
- vc_valid_ld  out  vc_size  one-hot valid write enable
- vc_valid_datain  out  1  valid write data
- vc_dirty_ld  out  vc_size  one-hot dirty write enable
- vc_dirty_datain  out  1  dirty write data
- vc_plru_ld  out  1  pointer write enable
- vc_plru_datain  out  num_idx_bits  next pointer
- vc_valid_read, vc_dirty_read, vc_plru_read  out  1  read strobes to the metadata store
- vc_line_ld  out  vc_size  one-hot tag+data write enable (L1 victim into entry)
- vc_rd_idx  out  num_idx_bits  entry selected onto the VC data/tag output mux
- l1_resp  out  1  one-cycle completion pulse
- l1_hit  out  1  valid with l1_resp; 1 = VC supplied the line
- l2_wb_req  out  1  writeback request, held until l2_wb_resp
- l2_wb_resp  in  1  L2 writeback done, one-cycle pulse

Behaviour:
- Reset: state IDLE. All outputs 0, except vc_rd_idx = 0.
  - Reset dominates every state, including WB_WAIT with l2_wb_req high.
  - Reset drops l2_wb_req the next cycle; any later l2_wb_resp is ignored.
- Read strobes: vc_valid_read, vc_dirty_read and vc_plru_read are held 1 in every state except IDLE.
- IDLE:
  - l1_req = 1 -> LOOKUP.
- LOOKUP (1 cycle; hit vector sampled here):
  - hit = |vc_hit_vec; hit_idx = index of the lowest set bit of vc_hit_vec. More than one bit set is illegal; the bench asserts it never happens.
  - Victim index vidx = lowest index with vc_valid_dataout = 0 if any exists, else vc_plru_dataout. vidx is registered.
  - hit -> SWAP.
  - miss and !l1_victim_valid -> RESP.
  - miss and the entry at vidx is valid and dirty -> WB_REQ.
  - otherwise -> INSERT.
- SWAP (1 cycle):
  - vc_rd_idx = hit_idx.
  - If l1_victim_valid: vc_line_ld[hit_idx] = 1; vc_valid_ld[hit_idx] = 1 with datain 1; vc_dirty_ld[hit_idx] = 1 with datain l1_victim_dirty.
  - If !l1_victim_valid: vc_valid_ld[hit_idx] = 1 with datain 0, which invalidates the entry.
  - PLRU is untouched.
  - -> RESP with l1_hit = 1.
- WB_REQ:
  - vc_rd_idx = vidx, l2_wb_req = 1. -> WB_WAIT.
- WB_WAIT:
  - l2_wb_req stays 1 and vc_rd_idx stays vidx.
  - On l2_wb_resp: vc_dirty_ld[vidx] = 1 with datain 0, then -> INSERT.
  - No timeout.
- INSERT (1 cycle):
  - vc_line_ld[vidx] = 1; valid <- 1; dirty <- l1_victim_dirty.
  - vc_plru_ld = 1 with vc_plru_datain = (vidx + 1) mod vc_size. The wrap is natural num_idx_bits overflow when vc_size is a power of two; otherwise an explicit compare is required.
  - -> RESP with l1_hit = 0.
- RESP (1 cycle):
  - l1_resp = 1; l1_hit is held from the registered decision. -> IDLE.
  - A new l1_req is not accepted until IDLE, so minimum request spacing is 3 cycles.
- Latency from l1_req to l1_resp: hit 3 cycles; clean miss 3; miss without victim 2; dirty miss 4 + L2 latency.
- The ld vectors are always one-hot or all-zero.
- l1_victim_valid and l1_victim_dirty must be stable while l1_req is held.

Decomposition:
- Package vc_pkg:
  - vc_state_t enum {IDLE, LOOKUP, SWAP, WB_REQ, WB_WAIT, INSERT, RESP};
  - function onehot(idx) returning vc_size bits;
  - VC_SIZE and IDX_W constants.
- One sub-module, vc_victim_select: combinational priority-encode of the first invalid entry, with fallback to the PLRU pointer, plus the hit-index encoder.

Test Plan:
1. Cold start, all entries invalid, l1_req with victim valid/clean -> IDLE, LOOKUP, INSERT, RESP; vc_line_ld = 8'h01; plru_datain = 1; l1_resp with l1_hit = 0 three cycles after the request.
2. vc_hit_vec = 8'h20 with a dirty L1 victim -> SWAP with vc_rd_idx = 5; vc_line_ld = 8'h20; dirty_datain = 1; plru_ld never asserted; l1_hit = 1.
3. All entries valid, plru = 3, entry 3 dirty, miss -> l2_wb_req held 7 cycles until resp; dirty_ld = 8'h08 with datain 0, then INSERT at index 3; plru_datain = 4.
4. All valid, plru = 7, clean miss -> insert at 7; plru_datain wraps to 0.
5. Hit with l1_victim_valid = 0 -> valid_ld[hit_idx] with datain 0; no line load.
6. Reset asserted (rst = 0) during WB_WAIT -> the next cycle shows state IDLE with all outputs 0; a late l2_wb_resp produces no ld activity.
